// File: rtl/uart_hex_nibble_rx_pkg.sv
// rtl/uart_hex_nibble_rx_pkg.sv - shared types, ASCII constants and hex decode for the UART nibble receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_9   = 8'h39;
    localparam logic [7:0] ASCII_UA  = 8'h41;
    localparam logic [7:0] ASCII_UF  = 8'h46;
    localparam logic [7:0] ASCII_LA  = 8'h61;
    localparam logic [7:0] ASCII_LF  = 8'h66;
    localparam logic [7:0] ASCII_SP  = 8'h20;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_NL  = 8'h0A;
    localparam logic [7:0] ASCII_TAB = 8'h09;

    typedef struct packed {
        logic       valid;
        logic       ws;
        logic [3:0] nib;
    } hex_dec_t;

    function automatic hex_dec_t hex2nib(input logic [7:0] b);
        hex_dec_t r;
        r = '0;
        if (b >= ASCII_0 && b <= ASCII_9) begin
            r.valid = 1'b1;
            r.nib   = b[3:0];
        end else if ((b >= ASCII_UA && b <= ASCII_UF) || (b >= ASCII_LA && b <= ASCII_LF)) begin
            // low nibble of 'A'/'a' is 1, so +9 lands on 10
            r.valid = 1'b1;
            r.nib   = b[3:0] + 4'd9;
        end else if (b == ASCII_SP || b == ASCII_CR || b == ASCII_NL || b == ASCII_TAB) begin
            r.ws = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_hex_nibble_rx_if.sv
// rtl/uart_hex_nibble_rx_if.sv - nibble stream and status bundle from receiver to loader
interface uart_hex_nibble_rx_if;
    logic [3:0] dout_o;
    logic       rx_done_tick_o;
    logic       char_err_o;
    logic       frame_err_o;
    logic       busy_o;

    modport master (output dout_o, rx_done_tick_o, char_err_o, frame_err_o, busy_o);
    modport slave  (input  dout_o, rx_done_tick_o, char_err_o, frame_err_o, busy_o);
endinterface

// File: rtl/uart_hex_nibble_rx_sync.sv
// rtl/uart_hex_nibble_rx_sync.sv - 2-FF synchroniser for rx plus registered falling-edge pulse
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic s1_q, s2_q, prev_q, fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= rx_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            fall_q <= prev_q & ~s2_q;
        end
    end

    assign rx_s_o = s2_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/uart_hex_nibble_rx.sv
// rtl/uart_hex_nibble_rx.sv - UART 8N1 receiver decoding ASCII hex into a nibble stream
// UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit sample, decision one clock later.
module uart_hex_nibble_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_i,
    uart_hex_nibble_rx_if.master   rx_if
);

    localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
    localparam int CW        = $clog2(BIT_TICKS);
    localparam logic [CW-1:0] TICK_LAST = CW'(BIT_TICKS - 1);

    logic rx_s, fall, bit_smp;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rx_i),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // Start decision one tick late shifts every later decision to mid+1 as well.
    localparam logic [CW-1:0] TICK_START = CW'(BIT_TICKS / 2);
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= {hist_q[0], rx_s};
    end

    assign bit_smp = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    localparam logic [CW-1:0] TICK_START = CW'(BIT_TICKS / 2 - 1);
    assign bit_smp = rx_s;
`endif

    rx_state_e  state_q;
    logic [CW-1:0] tick_q;
    logic [2:0] bit_q;
    logic [7:0] shift_q;
    logic [3:0] dout_q;
    logic       done_q, cerr_q, ferr_q;
    hex_dec_t   dec;

    assign dec = hex2nib(shift_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            cerr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cerr_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q <= START;
                        tick_q  <= '0;
                    end
                end
                START: begin
                    if (tick_q == TICK_START) begin
                        tick_q  <= '0;
                        bit_q   <= '0;
                        state_q <= bit_smp ? IDLE : DATA;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q          <= '0;
                        shift_q[bit_q]  <= bit_smp;
                        bit_q           <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (!bit_smp) begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end else begin
                            state_q <= IDLE;
                            if (dec.valid) begin
                                dout_q <= dec.nib;
                                done_q <= 1'b1;
                            end else if (!dec.ws) begin
                                cerr_q <= 1'b1;
                            end
                        end
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                end
                // Held-low line stays here so it reports a single frame error.
                BREAK: begin
                    if (rx_s) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_if.dout_o         = dout_q;
    assign rx_if.rx_done_tick_o = done_q;
    assign rx_if.char_err_o     = cerr_q;
    assign rx_if.frame_err_o    = ferr_q;
    assign rx_if.busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_hex_nibble_rx.sv
// tb/tb_uart_hex_nibble_rx.sv - randomized and directed bench for uart_hex_nibble_rx against a byte-level model
module tb_uart_hex_nibble_rx;

    localparam int BT = 10;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT = (19 * BT) / 2 + 4 + MAJ;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    uart_hex_nibble_rx_if u_if ();

    uart_hex_nibble_rx #(
        .CLK_FREQ  (1_000_000),
        .BAUD_RATE (100_000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_i  (rx),
        .rx_if (u_if.master)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int c_done, c_cerr, c_ferr, lat, busy_seen;
    int exp_dout = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // 0 = hex digit, 1 = whitespace, 2 = anything else
    function automatic int classify(input int v, output int nib);
        nib = 0;
        if (v >= 48 && v <= 57)       begin nib = v - 48; return 0; end
        else if (v >= 65 && v <= 70)  begin nib = v - 55; return 0; end
        else if (v >= 97 && v <= 102) begin nib = v - 87; return 0; end
        else if (v == 32 || v == 13 || v == 10 || v == 9) return 1;
        return 2;
    endfunction

    task automatic observe(input int i);
        if (u_if.rx_done_tick_o) c_done++;
        if (u_if.char_err_o)     c_cerr++;
        if (u_if.frame_err_o)    c_ferr++;
        if (u_if.busy_o)         busy_seen = 1;
        if ((u_if.rx_done_tick_o || u_if.char_err_o || u_if.frame_err_o) && lat < 0) lat = i;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop, input int flip, input int tail_low);
        int   total;
        int   k;
        logic v;
        total = 10 * BT + tail_low + 3 * BT;
        c_done = 0; c_cerr = 0; c_ferr = 0; lat = -1; busy_seen = 0;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            k = i / BT;
            if (k == 0)                         v = 1'b0;
            else if (k <= 8)                    v = b[k-1];
            else if (k == 9)                    v = stop;
            else if (i < 10 * BT + tail_low)    v = 1'b0;
            else                                v = 1'b1;
            if (i == flip) v = ~v;
            rx = v;
            observe(i);
        end
    endtask

    task automatic run_byte(input string tag, input logic [7:0] b, input bit stop,
                            input int flip, input int tail_low, input logic [7:0] seen);
        int kind, nib, e_done, e_cerr, e_ferr;
        kind   = classify(int'(seen), nib);
        e_done = (stop && kind == 0) ? 1 : 0;
        e_cerr = (stop && kind == 2) ? 1 : 0;
        e_ferr = stop ? 0 : 1;
        if (e_done == 1) exp_dout = nib;
        send_frame(b, stop, flip, tail_low);
        check({tag, ".done"}, c_done, e_done);
        check({tag, ".cerr"}, c_cerr, e_cerr);
        check({tag, ".ferr"}, c_ferr, e_ferr);
        check({tag, ".dout"}, u_if.dout_o, exp_dout);
        if (e_done + e_cerr + e_ferr > 0) check({tag, ".lat"}, lat, LAT);
        check({tag, ".busy"}, u_if.busy_o, 0);
    endtask

    logic [7:0] ws_tab [4] = '{8'h20, 8'h0D, 8'h0A, 8'h09};

    initial begin
        logic [7:0] b;
        bit         stop;

        repeat (2) @(negedge clk);
        check("rst.dout", u_if.dout_o, 0);
        check("rst.done", u_if.rx_done_tick_o, 0);
        check("rst.cerr", u_if.char_err_o, 0);
        check("rst.ferr", u_if.frame_err_o, 0);
        check("rst.busy", u_if.busy_o, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        run_byte("A", 8'h41, 1, -1, 0, 8'h41);
        run_byte("f", 8'h66, 1, -1, 0, 8'h66);
        run_byte("7", 8'h37, 1, -1, 0, 8'h37);

        run_byte("lf", 8'h0A, 1, -1, 0, 8'h0A);
        run_byte("G",  8'h47, 1, -1, 0, 8'h47);

        run_byte("brk",   8'h35, 0, -1, 300, 8'h35);
        run_byte("3",     8'h33, 1, -1, 0, 8'h33);

        // short low glitch on an idle line
        c_done = 0; c_cerr = 0; c_ferr = 0; lat = -1; busy_seen = 0;
        for (int i = 0; i < 3 * BT; i++) begin
            @(negedge clk);
            rx = (i < 3) ? 1'b0 : 1'b1;
            observe(i);
        end
        check("glitch.pulses", c_done + c_cerr + c_ferr, 0);
        check("glitch.busy_seen", busy_seen, 1);
        check("glitch.busy_end", u_if.busy_o, 0);

        // reset in the middle of data bit 4 of 'C'
        b = 8'h43;
        for (int i = 0; i < 5 * BT + 5; i++) begin
            @(negedge clk);
            rx = (i < BT) ? 1'b0 : b[i / BT - 1];
        end
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check("midrst.dout", u_if.dout_o, 0);
        check("midrst.done", u_if.rx_done_tick_o, 0);
        check("midrst.cerr", u_if.char_err_o, 0);
        check("midrst.ferr", u_if.frame_err_o, 0);
        check("midrst.busy", u_if.busy_o, 0);
        exp_dout = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * BT) @(negedge clk);
        run_byte("C", 8'h43, 1, -1, 0, 8'h43);

        // one-clock inversion where the receiver takes its bit-2 sample
        run_byte("Bflip", 8'h42, 1, BT * 3 + BT / 2 + 1, 0, (MAJ == 1) ? 8'h42 : 8'h46);

        for (int n = 0; n < 14; n++) begin
            case ($urandom_range(0, 3))
                0:       b = 8'($urandom_range(48, 57));
                1:       b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(65, 70)) : 8'($urandom_range(97, 102));
                2:       b = ws_tab[$urandom_range(0, 3)];
                default: b = 8'($urandom_range(0, 255));
            endcase
            stop = ($urandom_range(0, 7) != 0);
            run_byte($sformatf("rnd%0d", n), b, stop, -1, 0, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
